// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline defines: stall encoding, NOP field values and the stage-action
// enum used by pipeline registers and by the stall controller's assertions.
package pipe_stage_reg_pkg;

    // Stall vector encoding driven by the stall controller.
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // NOP field values loaded on bubble, flush and reset.
    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        WriteEnable  = 1'b1;

    localparam int STALL_W = 6;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // Priority: flush, then bubble, then hold; the illegal NoStop/Stop pattern loads.
    function automatic stage_act_e decode_action(
        input logic flush,
        input logic s_here,
        input logic s_next
    );
        if (flush)
            return ACT_FLUSH;
        if (s_here == Stop && s_next == NoStop)
            return ACT_BUBBLE;
        if (s_here == Stop && s_next == Stop)
            return ACT_HOLD;
        return ACT_LOAD;
    endfunction

    function automatic logic act_is_bubble(input stage_act_e act);
        return act == ACT_BUBBLE;
    endfunction

    function automatic logic act_is_hold(input stage_act_e act);
        return act == ACT_HOLD;
    endfunction

    function automatic logic act_is_flush(input stage_act_e act);
        return act == ACT_FLUSH;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; used for pipeline profiling events.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic at_max;

    assign at_max = &q;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && !at_max)
            q <= q + W'(1);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid bit, flush, full NOP
// clearing on bubble, and saturating bubble/hold/flush event counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int STAGE  = 1,
    parameter int AOP_W  = 8,
    parameter int ASEL_W = 3,
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                cnt_clr,
    input  logic                in_valid,
    input  logic [AOP_W-1:0]    in_aluop,
    input  logic [ASEL_W-1:0]   in_alusel,
    input  logic [DATA_W-1:0]   in_reg1,
    input  logic [DATA_W-1:0]   in_reg2,
    input  logic [RA_W-1:0]     in_wd,
    input  logic                in_wreg,
    input  logic [DATA_W-1:0]   in_inst,
    output logic                out_valid,
    output logic [AOP_W-1:0]    out_aluop,
    output logic [ASEL_W-1:0]   out_alusel,
    output logic [DATA_W-1:0]   out_reg1,
    output logic [DATA_W-1:0]   out_reg2,
    output logic [RA_W-1:0]     out_wd,
    output logic                out_wreg,
    output logic [DATA_W-1:0]   out_inst,
    output logic [CNT_W-1:0]    cnt_bubble,
    output logic [CNT_W-1:0]    cnt_hold,
    output logic [CNT_W-1:0]    cnt_flush
);

    logic       s_here;
    logic       s_next;
    logic       stall_unused;
    stage_act_e act;
    logic       inc_bubble;
    logic       inc_hold;
    logic       inc_flush;

    assign s_here       = stall[STAGE];
    assign s_next       = stall[STAGE+1];
    // Only two bits of the stall vector matter at any one boundary.
    assign stall_unused = ^stall;

    assign act = decode_action(flush, s_here, s_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_aluop  <= AOP_W'(EXE_NOP_OP);
            out_alusel <= ASEL_W'(EXE_RES_NOP);
            out_reg1   <= DATA_W'(ZeroWord);
            out_reg2   <= DATA_W'(ZeroWord);
            out_wd     <= RA_W'(NOPRegAddr);
            out_wreg   <= WriteDisable;
            out_inst   <= DATA_W'(ZeroWord);
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_valid  <= 1'b0;
                    out_aluop  <= AOP_W'(EXE_NOP_OP);
                    out_alusel <= ASEL_W'(EXE_RES_NOP);
                    out_reg1   <= DATA_W'(ZeroWord);
                    out_reg2   <= DATA_W'(ZeroWord);
                    out_wd     <= RA_W'(NOPRegAddr);
                    out_wreg   <= WriteDisable;
                    out_inst   <= DATA_W'(ZeroWord);
                end
                ACT_HOLD: begin
                    out_valid <= out_valid;
                end
                default: begin
                    out_valid  <= in_valid;
                    out_aluop  <= in_aluop;
                    out_alusel <= in_alusel;
                    out_reg1   <= in_reg1;
                    out_reg2   <= in_reg2;
                    out_wd     <= in_wd;
                    // An invalid slot must never write the register file.
                    out_wreg   <= in_wreg & in_valid;
                    out_inst   <= in_inst;
                end
            endcase
        end
    end

    assign inc_bubble = act_is_bubble(act);
    assign inc_hold   = act_is_hold(act);
    // Only squashes of a real instruction are interesting for profiling.
    assign inc_flush  = act_is_flush(act) && out_valid;

    sat_counter #(.W(CNT_W)) u_cnt_bubble (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (inc_bubble),
        .q   (cnt_bubble)
    );

    sat_counter #(.W(CNT_W)) u_cnt_hold (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (inc_hold),
        .q   (cnt_hold)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (inc_flush),
        .q   (cnt_flush)
    );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core. It replaces the fixed decode-to-execute latch and is usable at any stage boundary selected by `STAGE`. Over the single-purpose latch it adds:
- a `valid` bit;
- a synchronous `flush` for branch and exception squash;
- complete NOP clearing of every field on bubble, including the instruction word;
- three saturating event counters (bubble, hold, flush) for pipeline profiling.

## Interface
Parameters:
- `STAGE`, 1, index `i` into `stall`; the register sits between stage `i` and `i+1`; legal range 0..4.
- `AOP_W`, 8, ALU-op field width.
- `ASEL_W`, 3, ALU-select field width.
- `DATA_W`, 32, operand and instruction width.
- `RA_W`, 5, destination register-address width.
- `CNT_W`, 16, event counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall` in 6: pipeline stall vector from the stall controller, `Stop`/`NoStop` encoding.
- `flush` in 1: squash request; converts the stage into a bubble on the next edge.
- `cnt_clr` in 1: synchronous clear of all three counters.
- `in_valid` in 1: upstream slot holds a real instruction.
- `in_aluop` in AOP_W, `in_alusel` in ASEL_W, `in_reg1` in DATA_W, `in_reg2` in DATA_W, `in_wd` in RA_W, `in_wreg` in 1, `in_inst` in DATA_W: upstream payload.
- `out_valid` out 1, `out_aluop`, `out_alusel`, `out_reg1`, `out_reg2`, `out_wd`, `out_wreg`, `out_inst`: registered payload, same widths as the inputs.
- `cnt_bubble` out CNT_W, `cnt_hold` out CNT_W, `cnt_flush` out CNT_W: event counters.

## Operation
- **Stall decode:** `s_here = stall[STAGE]`, `s_next = stall[STAGE+1]`.
- **Per-edge action, priority high to low:**
  1. `rst`: clear state (asynchronous).
  2. `flush=1`: load NOP.
  3. `s_here=Stop && s_next=NoStop`: BUBBLE, load NOP.
  4. `s_here=Stop && s_next=Stop`: HOLD, all outputs keep their value.
  5. otherwise: LOAD.
- **NOP value:**
  - `out_valid=0`, `out_aluop=EXE_NOP_OP`, `out_alusel=EXE_RES_NOP`.
  - `out_reg1`, `out_reg2`, `out_inst` = `ZeroWord`.
  - `out_wd=NOPRegAddr`, `out_wreg=WriteDisable`.
- **LOAD:** all payload fields copied. `out_valid=in_valid`. `out_wreg=in_wreg & in_valid`, so an invalid slot never writes the register file.
- **Counters** (each saturates at all-ones and never wraps):
  - `cnt_bubble` increments on every BUBBLE edge.
  - `cnt_hold` increments on every HOLD edge.
  - `cnt_flush` increments on every flush edge where `out_valid` was 1 before the edge, i.e. a real instruction was killed.
- **Counter clear:** `cnt_clr` clears all counters to 0 and takes priority over any increment in the same cycle.
- **Flush during stall:** flush overrides both BUBBLE and HOLD. It is counted only in `cnt_flush`, not in `cnt_bubble` or `cnt_hold`.
- **Illegal stall pattern:** `s_here=NoStop && s_next=Stop` is illegal from the stall controller. The block performs LOAD; the bench flags it as an assertion error.

## Timing
- **Reset:** `rst` asserted forces NOP values on all payload outputs and zeros all counters, immediately and independent of `clk`. Release is synchronised externally.
- **Latency:** 1 cycle from input to output on LOAD; 0 cycles for the combinational stall decode.
- **Bubble/flush visibility:** the NOP appears on the outputs the cycle after the request edge.
- **HOLD:** lasts exactly as long as both stall bits are Stop. The first edge after release performs LOAD of the current inputs.
- **Reset mid-HOLD or mid-flush:** reset wins. The first post-reset edge evaluates normally.

## Structure
- **Shared constants:** `Stop`, `NoStop`, `EXE_NOP_OP`, `EXE_RES_NOP`, `NOPRegAddr`, `ZeroWord`, `WriteDisable` come from the shared defines file. No local redefinition.
- **Stage-action enum:** LOAD/HOLD/BUBBLE/FLUSH also goes in the shared defines, for reuse by the stall controller's assertions.
- **Sub-module `sat_counter`:** parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `q`. Instantiated three times.

## Test plan
- **Reset:** `rst=1` with arbitrary inputs -> all outputs NOP, `out_valid=0`, counters 0, before any clock edge.
- **LOAD then HOLD:** `in_aluop=8'h21`, `in_reg1=32'h1234`, `in_valid=1`, stall=0 -> values appear after 1 edge. Then `stall[STAGE]=stall[STAGE+1]=1` for 3 cycles -> outputs unchanged, `cnt_hold=3`.
- **BUBBLE:** `stall[STAGE]=1`, `stall[STAGE+1]=0` for 2 edges with valid input -> NOP output, `out_inst=0`, `cnt_bubble=2`.
- **Flush over HOLD:** `out_valid=1`, both stall bits Stop, `flush=1` -> NOP next edge, `cnt_flush=1`, `cnt_hold` unchanged. A second flush edge with `out_valid=0` -> `cnt_flush` stays 1.
- **Invalid slot:** `in_valid=0`, `in_wreg=1` -> `out_wreg=0`, `out_valid=0`.
- **Saturation and clear:** `CNT_W=2`, 5 bubble edges -> `cnt_bubble=3`. Then `cnt_clr=1` together with a bubble -> `cnt_bubble=0`.
